// File: rtl/io_map_pkg.sv
// Shared definitions for Risc32 memory-mapped io peripherals.
// Holds the register offsets, the STATUS bit positions, the funct3 load/store
// size codes and the UART transmitter state type.
package io_map_pkg;

  // Byte offsets inside a 16-byte register window.
  localparam logic [3:0] OFF_TXDATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_DIVISOR  = 4'h8;
  localparam logic [3:0] OFF_RESERVED = 4'hC;

  // STATUS register bit positions.
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  // funct3 access size codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // True for byte-wide stores (signed and unsigned codes alike).
  function automatic logic is_byte_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU:       return 1'b1;
      F3_H, F3_HU, F3_W: return 1'b0;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with free-running wrap-around pointers.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers to 0)
//   push, din       write request/data; ignored while full
//   pop             read request; ignored while empty
//   dout            head entry (valid while !empty)
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo DEPTH must be a power of 2 in 2..256");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // One extra pointer bit distinguishes full from empty; subtraction wraps.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Risc32 io bus.
// Registers (word aligned, BASE_ADDR + offset):
//   0x0 TXDATA  W   push byte into TX FIFO (reads 0)
//   0x4 STATUS  R   {count[15:8], ovf[3], empty[2], full[1], busy[0]}; read clears ovf
//   0x8 DIVISOR R/W clock cycles per bit (0 behaves as 1)
//   0xC reserved
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   io_address               byte address from core
//   io_write_value           store data
//   io_write_en              store strobe (edge sampled)
//   io_read_en               load strobe (combinational)
//   io_data_size             funct3 access size
//   io_read_value            register read data, 0 when not selected
//   sel                      address hits the register window
//   uart_tx                  serial line, idle high
module io_uart_tx
  import io_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [2:0]  io_data_size,
  output logic [31:0] io_read_value,
  output logic        sel,
  output logic        uart_tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Address decode
  logic [3:0] offset;
  logic       reg_wr;
  logic       push;
  logic       status_rd;

  assign sel       = (io_address[31:4] == BASE_ADDR[31:4]) && (io_address[1:0] == 2'b00);
  assign offset    = {io_address[3:2], 2'b00};
  assign reg_wr    = io_write_en && sel;
  assign push      = reg_wr && (offset == OFF_TXDATA);
  assign status_rd = io_read_en && sel && (offset == OFF_STATUS);

  // Only the low half-word of store data is ever consumed.
  logic unused_wdata;
  assign unused_wdata = ^io_write_value[31:16];

  // TX FIFO
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .din   (io_write_value[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Divisor and sticky overflow
  logic [15:0] divisor;
  logic        overflow;
  logic        ovf_event;
  logic [15:0] div_reload;

  assign ovf_event  = push && fifo_full;
  assign div_reload = (divisor == '0) ? '0 : divisor - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (reg_wr && (offset == OFF_DIVISOR)) begin
        if (is_byte_size(io_data_size)) begin
          divisor[7:0] <= io_write_value[7:0];
        end else begin
          divisor <= io_write_value[15:0];
        end
      end
      // A drop in the same cycle as a STATUS read keeps the flag set.
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (status_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serialiser FSM
  tx_state_e   state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic        tx_d;

  // Each bit reloads the counter from the live divisor, so a divisor write
  // only takes effect at the next bit boundary.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          bit_d    = '0;
          baud_d   = div_reload;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (baud_q == '0) begin
          baud_d  = div_reload;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (baud_q == '0) begin
          baud_d = div_reload;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (baud_q == '0) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    // Line level is registered from the next state to keep uart_tx glitch-free.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      uart_tx <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      uart_tx <= tx_d;
    end
  end

  // Register read
  logic [8:0]  count_ext;
  logic [31:0] status_word;

  assign count_ext = 9'(fifo_count);

  always_comb begin
    status_word                           = '0;
    status_word[ST_BUSY]                  = (state_q != TX_IDLE);
    status_word[ST_FULL]                  = fifo_full;
    status_word[ST_EMPTY]                 = fifo_empty;
    status_word[ST_OVF]                   = overflow;
    status_word[ST_COUNT_LSB +: 8]        = count_ext[8] ? 8'hFF : count_ext[7:0];
  end

  always_comb begin
    io_read_value = '0;
    if (sel && io_read_en) begin
      case (offset)
        OFF_STATUS:   io_read_value = status_word;
        OFF_DIVISOR:  io_read_value = {16'b0, divisor};
        OFF_RESERVED: io_read_value = '0;
        default:      io_read_value = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
module tb_io_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_address = '0;
  logic [31:0] io_write_value = '0;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [2:0]  io_data_size = 3'b010;
  logic [31:0] io_read_value;
  logic        sel;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .io_address     (io_address),
    .io_write_value (io_write_value),
    .io_write_en    (io_write_en),
    .io_read_en     (io_read_en),
    .io_data_size   (io_data_size),
    .io_read_value  (io_read_value),
    .sel            (sel),
    .uart_tx        (uart_tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The line is modelled as a queue of per-cycle samples: a popped byte
  // expands into 10*eff frame samples followed by one idle sample.
  typedef struct packed {
    logic val;
    logic busy;
  } sample_t;

  byte unsigned fifo_q[$];
  sample_t      line_q[$];
  byte unsigned sent_log[$];
  logic         m_ovf;
  logic [15:0]  m_div;

  function automatic logic m_sel(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'd16) && ((a % 4) == 0);
  endfunction

  function automatic logic m_busy();
    return (line_q.size() != 0) ? line_q[0].busy : 1'b0;
  endfunction

  function automatic logic m_tx();
    return (line_q.size() != 0) ? line_q[0].val : 1'b1;
  endfunction

  function automatic logic m_quiet();
    return (fifo_q.size() == 0) && !m_busy();
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (a - BASE == 32'd4) begin
      v[0]    = m_busy();
      v[1]    = (fifo_q.size() == DEPTH);
      v[2]    = (fifo_q.size() == 0);
      v[3]    = m_ovf;
      v[15:8] = 8'(fifo_q.size());
    end else if (a - BASE == 32'd8) begin
      v = {16'b0, m_div};
    end
    return v;
  endfunction

  logic         mh;
  logic [31:0]  moff;
  int           mpre;
  logic         mevt;
  byte unsigned mb;
  int           meff;
  sample_t      ms;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q.delete();
      line_q.delete();
      m_ovf = 1'b0;
      m_div = 16'd434;
    end else begin
      mh   = m_sel(io_address);
      moff = io_address - BASE;
      if (line_q.size() != 0) void'(line_q.pop_front());
      mpre = fifo_q.size();
      mevt = 1'b0;
      if (line_q.size() == 0 && mpre != 0) begin
        mb = fifo_q.pop_front();
        sent_log.push_back(mb);
        meff = (m_div == 0) ? 1 : int'(m_div);
        for (int k = 0; k < 10; k++) begin
          ms.val  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : 1'((mb >> (k - 1)) & 1);
          ms.busy = 1'b1;
          for (int j = 0; j < meff; j++) line_q.push_back(ms);
        end
        ms.val  = 1'b1;
        ms.busy = 1'b0;
        line_q.push_back(ms);
      end
      if (io_write_en && mh && moff == 0) begin
        if (mpre < DEPTH) fifo_q.push_back(io_write_value[7:0]);
        else mevt = 1'b1;
      end
      if (io_write_en && mh && moff == 8) begin
        if (io_data_size == 3'b000 || io_data_size == 3'b100) m_div[7:0] = io_write_value[7:0];
        else m_div = io_write_value[15:0];
      end
      if (mevt) m_ovf = 1'b1;
      else if (io_read_en && mh && moff == 4) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx()});
      check("sel", {31'b0, sel}, {31'b0, m_sel(io_address)});
      check("rdata", io_read_value,
            (io_read_en && m_sel(io_address)) ? m_read(io_address) : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] last_rd;
  logic        last_sel;

  task automatic bus(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] wv, input logic [2:0] sz);
    io_write_en    = we;
    io_read_en     = re;
    io_address     = a;
    io_write_value = wv;
    io_data_size   = sz;
    #1;
    last_rd  = io_read_value;
    last_sel = sel;
    @(posedge clk);
    #1;
    io_write_en = 1'b0;
    io_read_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (!m_quiet() && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_bound", {31'b0, m_quiet()}, 32'd1);
  endtask

  logic [31:0] addrs [8];
  logic [2:0]  sizes [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5;
    int kind;
    logic [31:0] ad;

    addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 1, BASE + 2, BASE + 16, BASE - 4};
    sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    bus(0, 1, BASE + 4, 0, 3'b010);
    check("rst_status", last_rd, 32'h0000_0004);
    bus(0, 1, BASE + 8, 0, 3'b010);
    check("rst_div", last_rd, 32'd434);
    check("rst_line", {31'b0, uart_tx}, 32'd1);

    // 0x55 frame at divisor 4
    bus(1, 0, BASE + 8, 32'd4, 3'b010);
    bus(1, 0, BASE, 32'h55, 3'b000);
    check("lat_line_high", {31'b0, uart_tx}, 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("frame55_c%0d", c), {31'b0, uart_tx}, 32'((c / 4) % 2));
    end
    bus(0, 1, BASE + 4, 0, 3'b010);
    check("stop_busy", last_rd, 32'h0000_0005);
    bus(0, 1, BASE + 4, 0, 3'b010);
    check("after_stop", last_rd, 32'h0000_0004);

    // Back-to-back pushes at divisor 1, overflow
    bus(1, 0, BASE + 8, 32'd1, 3'b010);
    sent_log.delete();
    for (int i = 0; i < 9; i++) bus(1, 0, BASE, 32'(i), 3'b000);
    bus(1, 0, BASE, 32'h09, 3'b000);
    bus(0, 1, BASE + 4, 0, 3'b010);
    check("ovf_set", last_rd, 32'h0000_080B);
    bus(0, 1, BASE + 4, 0, 3'b010);
    check("ovf_cleared", last_rd, 32'h0000_0803);
    drain(400);
    check("sent_count", 32'(sent_log.size()), 32'd9);
    for (int i = 0; i < 9 && i < sent_log.size(); i++)
      check($sformatf("sent_%0d", i), 32'(sent_log[i]), 32'(i));

    // Divisor byte/half/word stores
    bus(1, 0, BASE + 8, 32'h1234, 3'b010);
    bus(1, 0, BASE + 8, 32'hAB, 3'b000);
    bus(0, 1, BASE + 8, 0, 3'b010);
    check("div_byte", last_rd, 32'h0000_12AB);
    bus(1, 0, BASE + 8, 32'hFFFF_5678, 3'b001);
    bus(0, 1, BASE + 8, 0, 3'b010);
    check("div_half", last_rd, 32'h0000_5678);
    bus(1, 0, BASE + 8, 32'h0, 3'b010);
    bus(0, 1, BASE + 8, 0, 3'b010);
    check("div_zero", last_rd, 32'h0);
    a5 = 8'hA5;
    bus(1, 0, BASE, 32'hA5, 3'b000);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("div0_c%0d", c), {31'b0, uart_tx},
            (c == 0) ? 32'd0 : (c == 9) ? 32'd1 : 32'(a5[c - 1]));
    end
    idle(1);

    // Decode boundaries
    bus(0, 1, BASE + 5, 0, 3'b010);
    check("mis_sel", {31'b0, last_sel}, 32'd0);
    check("mis_rd", last_rd, 32'd0);
    bus(1, 0, BASE + 1, 32'h77, 3'b000);
    bus(1, 0, BASE + 16, 32'h78, 3'b000);
    bus(0, 1, BASE + 4, 0, 3'b010);
    check("no_push", last_rd, 32'h0000_0004);
    bus(0, 1, BASE + 16, 0, 3'b010);
    check("oow_sel", {31'b0, last_sel}, 32'd0);
    check("oow_rd", last_rd, 32'd0);
    bus(1, 0, BASE + 12, 32'h5, 3'b010);
    bus(0, 1, BASE + 12, 0, 3'b010);
    check("rsv_sel", {31'b0, last_sel}, 32'd1);
    check("rsv_rd", last_rd, 32'd0);
    bus(0, 1, BASE + 8, 0, 3'b010);
    check("rsv_no_div", last_rd, 32'd0);

    // Randomised traffic
    bus(1, 0, BASE + 8, 32'd2, 3'b010);
    for (int it = 0; it < 1500; it++) begin
      kind = $urandom_range(0, 9);
      ad   = addrs[$urandom_range(0, 7)];
      if (kind <= 3) begin
        bus(1, 0, BASE, $urandom, sizes[$urandom_range(0, 4)]);
      end else if (kind <= 6) begin
        bus(0, 1, ad, $urandom, sizes[$urandom_range(0, 4)]);
      end else if (kind == 7) begin
        if (ad == BASE + 8 && !m_quiet()) bus(0, 1, ad, 0, 3'b010);
        else bus(1, 0, ad, (ad == BASE + 8) ? 32'($urandom_range(0, 3)) : $urandom,
                 sizes[$urandom_range(0, 4)]);
      end else begin
        idle(1);
      end
    end
    drain(2000);

    // Reset in the middle of data bit 3
    bus(1, 0, BASE + 8, 32'd4, 3'b010);
    bus(1, 0, BASE, 32'h00, 3'b000);
    bus(1, 0, BASE, 32'hFF, 3'b000);
    repeat (17) @(posedge clk);
    #2;
    check("pre_rst_line", {31'b0, uart_tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_async_line", {31'b0, uart_tx}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    bus(0, 1, BASE + 4, 0, 3'b010);
    check("post_rst_status", last_rd, 32'h0000_0004);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_line", {31'b0, uart_tx}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
